i2c_eeprom_master: RTL and testbench
====================================

# i2c_eeprom_master

Synthesizable I2C master that performs single-byte random writes and random reads on an AT24C02/04/08/16-class serial EEPROM (11-bit address, device code 1010). It sits between the system-side register/command logic and the two-wire bus, drives `scl`, and shares open-drain `sda` with the EEPROM. It converts a one-cycle request into a complete bus transaction and returns read data, completion and ACK status.

## Interface
- `QDIV`, default 50: system clocks per SCL quarter-period. SCL period = 4*QDIV clocks. Minimum legal value is one that makes a quarter-period ≥ 200 ns.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_req` input 1: one-cycle pulse that starts a write; sampled only while idle.
- `rd_req` input 1: one-cycle pulse that starts a random read; sampled only while idle.
- `addr` input 11: EEPROM byte address. `[10:8]` is the block select, `[7:0]` is the word address.
- `wdata` input 8: write data.
- `rdata` output 8: last byte read. Holds its value until the next read completes.
- `busy` output 1: high from the accepting cycle until the cycle `done` pulses, inclusive.
- `done` output 1: one-cycle pulse at the end of every transaction.
- `ack_err` output 1: valid with `done`. 1 means a slave ACK bit was sampled high. Held until the next accept.
- `scl` output 1: push-pull serial clock.
- `sda` inout 1: open-drain. Driven 0 when `sda_oe`=1, otherwise z. An external pull-up is required.

## Operation
- Reset values: `scl`=1, `sda` released, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0, FSM in IDLE.
- Request acceptance:
  - When idle, the block accepts a request and latches `addr` and `wdata`.
  - If `wr_req` and `rd_req` are high together, the write wins.
  - Requests arriving while `busy` are ignored, not queued.
- Control byte: CTRL = {4'b1010, addr[10:8], rw}, where rw=0 for write and rw=1 for read.
- Write sequence: START, CTRL(w), ACK, addr[7:0], ACK, wdata, ACK, STOP.
- Read sequence: START, CTRL(w), ACK, addr[7:0], ACK, RESTART, CTRL(r), ACK, 8 data bits (MSB first, `sda` released), master NACK (`sda` released), STOP.
- FSM states: IDLE → START → TX_BYTE → RX_ACK → (TX_BYTE | RESTART | RX_BYTE | STOP); RX_BYTE → TX_NACK → STOP → DONE → IDLE.
- Counters:
  - Quarter counter: 0..QDIV-1.
  - Phase counter: 2 bits, q0..q3.
  - Bit counter: 3 bits, counting down 7..0.
  - Byte index: 0..2, which selects CTRL, addr or wdata.
- ACK failure: if `sda`=1 at the sample point of any RX_ACK, the FSM sets `ack_err`=1, skips the remaining bytes, goes to STOP, then to DONE.
- `rdata` is updated only when a read completes without error.

## Timing
- Every bus element lasts exactly one SCL period, made of quarters q0..q3.
- Data bit (TX_BYTE, RX_ACK, RX_BYTE, TX_NACK):
  - q0 and q1: `scl`=0. `sda` is updated at the start of q0.
  - q2 and q3: `scl`=1.
  - `sda` is sampled on the q2→q3 boundary.
- START: q0 and q1 have `scl`=1 with `sda` released; q2 and q3 have `scl`=1 with `sda`=0.
- RESTART: q0 and q1 have `scl`=0 with `sda` released; q2 has `scl`=1 with `sda` released; q3 has `scl`=1 with `sda`=0.
- STOP: q0 and q1 have `scl`=0 with `sda`=0; q2 has `scl`=1 with `sda`=0; q3 has `scl`=1 with `sda` released.
- `sda` never changes while `scl`=1, except in START, RESTART and STOP.
- Latency from the accept cycle to the `done` cycle:
  - Write: 29 periods = 116*QDIV clocks.
  - Read: 39 periods = 156*QDIV clocks.
  - ACK error: (1 + 9k + 1) periods, where k is the number of bytes sent including the failing one.
- DONE lasts one clock, with `busy` still 1. IDLE follows, and a new request is accepted on the next cycle.
- Reset asserted mid-transaction: all outputs return to their reset values asynchronously, which leaves the bus with `scl`=1 and `sda` released. No STOP is generated.

## Structure
- Shared include `i2c_defs`:
  - FSM state encodings.
  - `EEPROM_DEV_CODE` = 4'b1010.
  - `RW_WRITE` = 0 and `RW_READ` = 1.
- One sub-module, `i2c_quarter_tick`, which counts to QDIV and emits a quarter tick plus the 2-bit phase. It is cleared on IDLE→START.
- The top level contains the FSM, shift register, bit/byte counters and output registers. `sda` is driven from a registered `sda_oe`.

## Test plan
- Write addr=11'h123, wdata=8'hA5 against the behavioural EEPROM model with `clk`=100 MHz, QDIV=50:
  - The model reports memory[123]=a5.
  - `done` pulses after 5800 clocks with `ack_err`=0.
- Read addr=11'h123 after the write:
  - `rdata`=8'hA5 on `done`.
  - `done` arrives 7800 clocks after the accept, with `ack_err`=0.
  - The bus monitor sees START, 0xA2, 0x23, RESTART, 0xA3, then NACK and STOP.
- No slave attached (pull-up only), write request:
  - `ack_err`=1 on `done`.
  - STOP follows the first ACK bit.
  - `done` arrives 11 periods (44*QDIV clocks) after the accept.
- `wr_req` and `rd_req` pulsed in the same cycle, addr=11'h7FF, wdata=8'h3C:
  - A write occurs (the model reports memory[7ff]=3c).
  - The second request, pulsed while `busy`, is ignored, and only one `done` pulse occurs.
- `rst_n` pulled low during the data byte of a write:
  - `scl`=1 and `sda`=z within the same time step.
  - `busy`=0 and `rdata` is unchanged.
  - A fresh write after reset completes normally.
- Protocol monitor across all scenarios: flags any `sda` edge while `scl`=1 outside START, RESTART and STOP, and checks that the SCL high and low times are each 2*QDIV clocks.

Source files
------------

// File: rtl/i2c_eeprom_master_pkg.sv
// rtl/i2c_eeprom_master_pkg.sv - shared definitions for the I2C EEPROM master
// Contents: FSM state encoding, EEPROM device code, R/W bit values,
//           and a helper that builds the control byte.
package i2c_eeprom_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_RX_ACK,
    ST_RESTART,
    ST_RX_BYTE,
    ST_TX_NACK,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic [3:0] EEPROM_DEV_CODE = 4'b1010;
  localparam logic       RW_WRITE        = 1'b0;
  localparam logic       RW_READ         = 1'b1;

  function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rw);
    return {EEPROM_DEV_CODE, blk, rw};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - SCL quarter-period timebase
// Ports: clk, rst_n   - clock, async active-low reset
//        clear        - restart at quarter 0 of phase q0
//        tick         - high on the last clock of each quarter
//        phase        - current quarter q0..q3
module i2c_quarter_tick #(
  parameter int QDIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int             CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(QDIV - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + ONE;
    end
  end

endmodule

// File: rtl/i2c_eeprom_master.sv
// rtl/i2c_eeprom_master.sv - I2C master for single-byte EEPROM write / random read
// Ports: clk, rst_n          - clock, async active-low reset
//        wr_req, rd_req      - one-cycle requests, sampled only when idle
//        addr[10:0], wdata   - byte address (block select in [10:8]) and write data
//        rdata               - last byte read successfully
//        busy, done, ack_err - transaction status
//        scl, sda            - bus clock (push-pull) and open-drain data
module i2c_eeprom_master
  import i2c_eeprom_master_pkg::*;
#(
  parameter int QDIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  state_t      state, next_state;
  logic        tick;
  logic [1:0]  phase;
  logic        accept, elem_end, sample_pt;
  logic [10:0] addr_q;
  logic [7:0]  wdata_q;
  logic        is_read, rd_phase, ack_bit;
  logic [7:0]  tx_sh, rx_sh;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic        scl_d, sda_oe_d, sda_oe;

  assign accept    = (state == ST_IDLE) && (wr_req || rd_req);
  assign elem_end  = tick && (phase == 2'd3);
  assign sample_pt = tick && (phase == 2'd2);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  i2c_quarter_tick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Bus levels are decoded per state/quarter and registered, so scl and
  // sda move together one clock after the quarter boundary.
  always_comb begin
    next_state = state;
    scl_d      = 1'b1;
    sda_oe_d   = 1'b0;
    case (state)
      ST_IDLE: if (accept) next_state = ST_START;
      ST_START: begin
        sda_oe_d = phase[1];
        if (elem_end) next_state = ST_TX_BYTE;
      end
      ST_TX_BYTE: begin
        scl_d    = phase[1];
        sda_oe_d = ~tx_sh[7];
        if (elem_end && bit_cnt == 3'd0) next_state = ST_RX_ACK;
      end
      ST_RX_ACK: begin
        scl_d = phase[1];
        if (elem_end) begin
          if (ack_bit)                              next_state = ST_STOP;
          else if (rd_phase)                        next_state = ST_RX_BYTE;
          else if (is_read && byte_idx == 2'd1)     next_state = ST_RESTART;
          else if (byte_idx == 2'd2)                next_state = ST_STOP;
          else                                      next_state = ST_TX_BYTE;
        end
      end
      ST_RESTART: begin
        scl_d    = phase[1];
        sda_oe_d = (phase == 2'd3);
        if (elem_end) next_state = ST_TX_BYTE;
      end
      ST_RX_BYTE: begin
        scl_d = phase[1];
        if (elem_end && bit_cnt == 3'd0) next_state = ST_TX_NACK;
      end
      ST_TX_NACK: begin
        scl_d = phase[1];
        if (elem_end) next_state = ST_STOP;
      end
      ST_STOP: begin
        scl_d    = phase[1];
        sda_oe_d = (phase != 2'd3);
        if (elem_end) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl    <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      scl    <= scl_d;
      sda_oe <= sda_oe_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      is_read  <= 1'b0;
      rd_phase <= 1'b0;
      ack_bit  <= 1'b0;
      ack_err  <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rdata    <= '0;
      bit_cnt  <= 3'd7;
      byte_idx <= 2'd0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        is_read  <= ~wr_req;   // write wins when both requests coincide
        rd_phase <= 1'b0;
        ack_err  <= 1'b0;
      end
      if (state == ST_RX_ACK && sample_pt) ack_bit <= sda;
      if (state == ST_RX_BYTE && sample_pt) rx_sh <= {rx_sh[6:0], sda};
      if (elem_end) begin
        case (state)
          ST_START: begin
            tx_sh    <= ctrl_byte(addr_q[10:8], RW_WRITE);
            byte_idx <= 2'd0;
            bit_cnt  <= 3'd7;
          end
          ST_RESTART: begin
            tx_sh    <= ctrl_byte(addr_q[10:8], RW_READ);
            byte_idx <= 2'd0;
            rd_phase <= 1'b1;
            bit_cnt  <= 3'd7;
          end
          ST_TX_BYTE, ST_RX_BYTE: begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
          ST_RX_ACK: begin
            bit_cnt  <= 3'd7;
            byte_idx <= byte_idx + 2'd1;
            tx_sh    <= (byte_idx == 2'd0) ? addr_q[7:0] : wdata_q;
            if (ack_bit) ack_err <= 1'b1;
          end
          ST_STOP: if (is_read && !ack_err) rdata <= rx_sh;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// tb/tb_i2c_eeprom_master.sv - directed bench with EEPROM model and bus monitor
`timescale 1ns/1ps
module tb_i2c_eeprom_master;

  localparam int QDIV    = 50;
  localparam int OP_WR   = 0;
  localparam int OP_RD   = 1;
  localparam int OP_BOTH = 2;
  localparam int T_START = 1000;
  localparam int T_RSTRT = 1001;
  localparam int T_STOP  = 1002;
  localparam int M_RX = 0, M_ACK = 1, M_TX = 2, M_MACK = 3, M_WAIT = 4;

  typedef struct {
    int          op;
    logic [10:0] addr;
    logic [7:0]  wdata;
    bit          en;      // slave attached
    int          nack;    // byte index the slave refuses (3 = none)
    bit          mid;     // pulse rd_req while busy
    int          lat;
    bit          err;
    logic [7:0]  rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [10:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy, done, ack_err, scl;
  wire         sda;

  int total = 0;
  int bad   = 0;

  logic slv_low = 1'b0;
  bit   slave_en = 1'b1;
  int   nack_idx = 3;
  logic [7:0] mem [0:2047];

  int tokens[$];
  int exp_tok[$];

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_eeprom_master #(.QDIV(QDIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // EEPROM slave model
  logic s_scl_p = 1'b1, s_sda_p = 1'b1;
  int s_mode = M_WAIT, s_bit = 0, s_idx = 0;
  logic [7:0] s_sh = '0;
  logic [10:0] s_addr = '0;
  logic s_rd = 1'b0;
  bit s_ok;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_mode = M_WAIT; slv_low = 1'b0;
    end else if (s_scl_p && scl && s_sda_p && !sda) begin
      s_mode = M_RX; s_bit = 0; s_idx = 0; slv_low = 1'b0;
    end else if (s_scl_p && scl && !s_sda_p && sda) begin
      s_mode = M_WAIT; slv_low = 1'b0;
    end else if (!s_scl_p && scl) begin
      if (s_mode == M_RX) begin s_sh = {s_sh[6:0], sda}; s_bit++; end
      else if (s_mode == M_TX) s_bit++;
    end else if (s_scl_p && !scl) begin
      case (s_mode)
        M_RX: if (s_bit == 8) begin
          s_ok = slave_en && (s_idx != nack_idx) && (s_idx != 0 || s_sh[7:4] == 4'b1010);
          if (s_ok) begin
            if (s_idx == 0) begin s_rd = s_sh[0]; s_addr[10:8] = s_sh[3:1]; end
            else if (s_idx == 1) s_addr[7:0] = s_sh;
            else if (!s_rd) mem[s_addr] = s_sh;
            s_mode = M_ACK; slv_low = 1'b1;
          end else s_mode = M_WAIT;
        end
        M_ACK: begin
          s_bit = 0;
          if (s_idx == 0 && s_rd) begin
            s_mode = M_TX; s_sh = mem[s_addr]; slv_low = !s_sh[7];
          end else begin
            s_mode = M_RX; slv_low = 1'b0; s_idx++;
          end
        end
        M_TX: if (s_bit == 8) begin slv_low = 1'b0; s_mode = M_MACK; end
              else slv_low = !s_sh[7-s_bit];
        M_MACK: s_mode = M_WAIT;
        default: ;
      endcase
    end
    s_scl_p = scl; s_sda_p = sda;
  end

  // Bus monitor: decodes conditions and bytes, checks SCL high/low widths
  logic m_scl_p = 1'b1, m_sda_p = 1'b1;
  bit m_active = 0, rise_ok = 0, fall_ok = 0;
  int m_bits = 0, cyc = 0, t_edge = 0;
  logic [8:0] m_sh = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; rise_ok = 0; fall_ok = 0; m_bits = 0;
    end else begin
      if (m_scl_p && scl && m_sda_p && !sda) begin
        tokens.push_back(m_active ? T_RSTRT : T_START);
        m_active = 1; m_bits = 0;
      end else if (m_scl_p && scl && !m_sda_p && sda) begin
        tokens.push_back(T_STOP);
        m_active = 0; m_bits = 0;
      end
      if (!m_scl_p && scl) begin
        if (fall_ok) chk("scl_low_time", cyc - t_edge, 2*QDIV);
        rise_ok = 1; t_edge = cyc;
        if (m_active) begin
          m_sh = {m_sh[7:0], sda}; m_bits++;
          if (m_bits == 9) begin
            tokens.push_back(int'(m_sh[8:1]) + (m_sh[0] ? 256 : 0));
            m_bits = 0;
          end
        end
      end else if (m_scl_p && !scl) begin
        if (rise_ok) chk("scl_high_time", cyc - t_edge, 2*QDIV);
        fall_ok = 1; t_edge = cyc;
      end
      if (done) rise_ok = 0;
    end
    m_scl_p = scl; m_sda_p = sda;
  end

  task automatic build_exp(input txn_t v);
    int cw;
    cw = int'({4'b1010, v.addr[10:8], 1'b0});
    exp_tok.delete();
    exp_tok.push_back(T_START);
    if (!v.en || v.nack == 0) begin
      exp_tok.push_back(cw + 256);
    end else begin
      exp_tok.push_back(cw);
      if (v.nack == 1) exp_tok.push_back(int'(v.addr[7:0]) + 256);
      else begin
        exp_tok.push_back(int'(v.addr[7:0]));
        if (v.op == OP_RD) begin
          exp_tok.push_back(T_RSTRT);
          exp_tok.push_back(cw + 1);
          exp_tok.push_back(int'(v.rdata) + 256);
        end else begin
          exp_tok.push_back(int'(v.wdata) + ((v.nack == 2) ? 256 : 0));
        end
      end
    end
    exp_tok.push_back(T_STOP);
  endtask

  task automatic run_txn(input txn_t v);
    int  k, dn;
    bit  seen;
    slave_en = v.en; nack_idx = v.nack;
    build_exp(v);
    @(posedge clk); #1;
    tokens.delete();
    addr = v.addr; wdata = v.wdata;
    wr_req = (v.op != OP_RD); rd_req = (v.op != OP_WR);
    @(posedge clk); #1;
    wr_req = 0; rd_req = 0;
    addr = ~v.addr; wdata = ~v.wdata;
    chk("busy_accept", busy, 1);
    k = 0; seen = 0;
    while (k < v.lat + 100) begin
      if (done) begin seen = 1; break; end
      rd_req = (v.mid && k == 100);
      @(posedge clk); #1; k++;
    end
    rd_req = 0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("latency", k, v.lat);
      chk("ack_err", ack_err, v.err);
      chk("rdata", rdata, v.rdata);
      chk("busy_done", busy, 1);
    end
    dn = 0;
    repeat (8*QDIV) begin @(posedge clk); #1; if (done) dn++; end
    chk("extra_done", dn, 0);
    chk("busy_idle", busy, 0);
    chk("ack_err_hold", ack_err, v.err);
    chk("tok_count", tokens.size(), exp_tok.size());
    for (int i = 0; i < exp_tok.size(); i++)
      if (i < tokens.size()) chk("bus_token", tokens[i], exp_tok[i]);
    if (v.op != OP_RD && v.en && !v.err) chk("mem", mem[v.addr], v.wdata);
  endtask

  txn_t tbl[9];
  txn_t fresh;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    tbl[0] = '{OP_WR,   11'h123, 8'hA5, 1'b1, 3, 1'b0, 116*QDIV, 1'b0, 8'h00};
    tbl[1] = '{OP_RD,   11'h123, 8'h00, 1'b1, 3, 1'b0, 156*QDIV, 1'b0, 8'hA5};
    tbl[2] = '{OP_WR,   11'h055, 8'h99, 1'b0, 3, 1'b0,  44*QDIV, 1'b1, 8'hA5};
    tbl[3] = '{OP_BOTH, 11'h7FF, 8'h3C, 1'b1, 3, 1'b1, 116*QDIV, 1'b0, 8'hA5};
    tbl[4] = '{OP_RD,   11'h7FF, 8'h00, 1'b1, 3, 1'b0, 156*QDIV, 1'b0, 8'h3C};
    tbl[5] = '{OP_RD,   11'h0AA, 8'h00, 1'b0, 3, 1'b0,  44*QDIV, 1'b1, 8'h3C};
    tbl[6] = '{OP_WR,   11'h200, 8'h11, 1'b1, 2, 1'b0, 116*QDIV, 1'b1, 8'h3C};
    tbl[7] = '{OP_RD,   11'h300, 8'h00, 1'b1, 1, 1'b0,  80*QDIV, 1'b1, 8'h3C};
    tbl[8] = '{OP_RD,   11'h010, 8'h00, 1'b1, 3, 1'b0, 156*QDIV, 1'b0, 8'h00};
    fresh  = '{OP_WR,   11'h0AB, 8'h77, 1'b1, 3, 1'b0, 116*QDIV, 1'b0, 8'h00};

    repeat (3) @(posedge clk); #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // reset while the data byte of a write is on the bus
    slave_en = 1; nack_idx = 3;
    @(posedge clk); #1;
    addr = 11'h0AB; wdata = 8'h77; wr_req = 1;
    @(posedge clk); #1;
    wr_req = 0;
    repeat (78*QDIV) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ack_err", ack_err, 0);
    chk("mid_rst_rdata", rdata, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    run_txn(fresh);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
